// File: rtl/rotation_angle_tracker.sv
// Tracks display spin period from IR beam-break rising edges and sweeps an angular
// slice index across each revolution using divider-free Bresenham accumulation.
module rotation_angle_tracker #(
    parameter int ROTATIONAL_RES = 1024,
    parameter int PERIOD_WIDTH   = 24,
    parameter int MIN_PERIOD     = 4096,
    parameter int MAX_PERIOD     = 2**24-1
) (
    input  logic                              clk_in,
    input  logic                              rst_in,
    input  logic                              ir_tripped,
    output logic [$clog2(ROTATIONAL_RES)-1:0] dtheta,
    output logic                              theta_strobe,
    output logic                              rev_strobe,
    output logic                              locked,
    output logic [PERIOD_WIDTH-1:0]           period_out,
    output logic [1:0]                        o_dbg_state
);

    localparam int TW = $clog2(ROTATIONAL_RES);
    localparam int AW = PERIOD_WIDTH + 1;
    localparam logic [PERIOD_WIDTH-1:0] MIN_P = PERIOD_WIDTH'(MIN_PERIOD);
    localparam logic [PERIOD_WIDTH-1:0] MAX_P = PERIOD_WIDTH'(MAX_PERIOD);
    localparam logic [AW-1:0]           RES_A = AW'(ROTATIONAL_RES);
    localparam logic [TW-1:0]           TOP   = TW'(ROTATIONAL_RES - 1);

    // Handshake: none; outputs are registered levels/pulses, strobes valid for one cycle.
    typedef enum logic [1:0] {
        S_UNLOCKED = 2'd0,
        S_ARMED    = 2'd1,
        S_LOCKED   = 2'd2
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_ir_prev;
    logic                    r_seen_low;
    logic [PERIOD_WIDTH-1:0] r_period_cnt;
    logic [AW-1:0]           r_acc;
    logic [TW-1:0]           r_dtheta;
    logic                    r_theta_strobe;
    logic                    r_rev_strobe;
    logic                    r_locked;
    logic [PERIOD_WIDTH-1:0] r_period_out;

    logic          w_edge;
    logic          w_long;
    logic          w_timeout;
    logic [AW-1:0] w_sum;
    logic [AW-1:0] w_period_ext;
    logic          w_cnt_clear;
    logic          w_restart;
    logic          w_drop;
    logic          w_advance_en;

    // r_seen_low suppresses a false edge when the beam is already broken at reset release.
    assign w_edge       = ir_tripped & ~r_ir_prev & r_seen_low;
    assign w_long       = (r_period_cnt >= MIN_P);
    assign w_timeout    = (r_period_cnt == MAX_P);
    assign w_sum        = r_acc + RES_A;
    assign w_period_ext = {1'b0, r_period_out};

    always_comb begin
        w_next_state = r_state;
        w_cnt_clear  = 1'b0;
        w_restart    = 1'b0;
        w_drop       = 1'b0;
        w_advance_en = 1'b0;
        case (r_state)
            S_UNLOCKED: begin
                if (w_edge) begin
                    w_next_state = S_ARMED;
                    w_cnt_clear  = 1'b1;
                end
            end
            S_ARMED: begin
                if (w_edge && w_long) begin
                    w_next_state = S_LOCKED;
                    w_restart    = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = S_UNLOCKED;
                end
            end
            S_LOCKED: begin
                if (w_edge && w_long) begin
                    w_restart = 1'b1;
                end else if (w_timeout) begin
                    w_next_state = S_UNLOCKED;
                    w_drop       = 1'b1;
                end else if (r_dtheta != TOP) begin
                    w_advance_en = 1'b1;
                end
            end
            default: w_next_state = S_UNLOCKED;
        endcase
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            r_state        <= S_UNLOCKED;
            r_ir_prev      <= 1'b0;
            r_seen_low     <= 1'b0;
            r_period_cnt   <= '0;
            r_acc          <= '0;
            r_dtheta       <= '0;
            r_theta_strobe <= 1'b0;
            r_rev_strobe   <= 1'b0;
            r_locked       <= 1'b0;
            r_period_out   <= '0;
        end else begin
            r_state        <= w_next_state;
            r_ir_prev      <= ir_tripped;
            r_seen_low     <= r_seen_low | ~ir_tripped;
            r_theta_strobe <= 1'b0;
            r_rev_strobe   <= 1'b0;

            if (w_cnt_clear || w_restart) begin
                r_period_cnt <= PERIOD_WIDTH'(1);
            end else if (!w_timeout) begin
                r_period_cnt <= r_period_cnt + PERIOD_WIDTH'(1);
            end

            if (w_restart) begin
                r_period_out   <= r_period_cnt;
                r_dtheta       <= '0;
                r_acc          <= '0;
                r_rev_strobe   <= 1'b1;
                r_theta_strobe <= 1'b1;
                r_locked       <= 1'b1;
            end else if (w_drop) begin
                r_dtheta <= '0;
                r_acc    <= '0;
                r_locked <= 1'b0;
            end else if (w_advance_en) begin
                // period_out >= ROTATIONAL_RES, so at most one slice per cycle.
                if (w_sum >= w_period_ext) begin
                    r_acc          <= w_sum - w_period_ext;
                    r_dtheta       <= r_dtheta + TW'(1);
                    r_theta_strobe <= 1'b1;
                end else begin
                    r_acc <= w_sum;
                end
            end
        end
    end

    assign dtheta       = r_dtheta;
    assign theta_strobe = r_theta_strobe;
    assign rev_strobe   = r_rev_strobe;
    assign locked       = r_locked;
    assign period_out   = r_period_out;
    assign o_dbg_state  = r_state;

endmodule

// File: tb/tb_rotation_angle_tracker.sv
// Bench for rotation_angle_tracker: a randomized IR waveform is planned up front, an
// edge-level reference model predicts every strobe/lock event, and a monitor checks them.
`timescale 1ns/1ps
module tb_rotation_angle_tracker;

    localparam int RES  = 64;
    localparam int PW   = 12;
    localparam int MINP = 256;
    localparam int MAXP = 4095;
    localparam int DW   = $clog2(RES);
    localparam int W    = 32 + DW + 3 + PW;

    logic          clk = 1'b0;
    logic          rst_in;
    logic          ir_tripped;
    logic [DW-1:0] dtheta;
    logic          theta_strobe;
    logic          rev_strobe;
    logic          locked;
    logic [PW-1:0] period_out;
    logic [1:0]    dbg_state;

    rotation_angle_tracker #(
        .ROTATIONAL_RES(RES),
        .PERIOD_WIDTH  (PW),
        .MIN_PERIOD    (MINP),
        .MAX_PERIOD    (MAXP)
    ) dut (
        .clk_in      (clk),
        .rst_in      (rst_in),
        .ir_tripped  (ir_tripped),
        .dtheta      (dtheta),
        .theta_strobe(theta_strobe),
        .rev_strobe  (rev_strobe),
        .locked      (locked),
        .period_out  (period_out),
        .o_dbg_state (dbg_state)
    );

    // clock
    always #5 clk = ~clk;

    bit             lvl_q[$];
    bit             rst_q[$];
    logic [W-1:0]   exp_q[$];
    int             n_tests = 0;
    int             n_fail  = 0;

    function automatic logic [W-1:0] pack(input int t, input int d, input bit rv,
                                          input bit th, input bit lk, input int p);
        logic [31:0]   tt;
        logic [DW-1:0] dd;
        logic [PW-1:0] pp;
        tt = t;
        dd = d[DW-1:0];
        pp = p[PW-1:0];
        return {tt, dd, rv, th, lk, pp};
    endfunction

    // stimulus planning
    task automatic add(input int n, input bit lv, input bit r);
        for (int i = 0; i < n; i++) begin
            lvl_q.push_back(lv);
            rst_q.push_back(r);
        end
    endtask

    task automatic rev(input int p);
        int h;
        h = $urandom_range(2, 20);
        add(h, 1'b1, 1'b0);
        add(p - h, 1'b0, 1'b0);
    endtask

    // revolution with a one-cycle glitch edge 100 cycles after the real edge
    task automatic grev(input int p);
        int h;
        h = $urandom_range(2, 20);
        add(h, 1'b1, 1'b0);
        add(100 - h, 1'b0, 1'b0);
        add(1, 1'b1, 1'b0);
        add(p - 101, 1'b0, 1'b0);
    endtask

    // reference model: slice k of a revolution of period P started at t0 appears at t0+ceil(k*P/RES)
    task automatic emit_adv(input int t0, input int p, input int t_end);
        int tk;
        for (int k = 1; k < RES; k++) begin
            tk = t0 + (k * p + RES - 1) / RES;
            if (tk < t_end) exp_q.push_back(pack(tk, k, 1'b0, 1'b1, 1'b1, p));
        end
    endtask

    task automatic build_model();
        int mode;
        int last_e;
        int per;
        int lock_t;
        int p;
        bit e;
        mode = 0; last_e = 0; per = 0; lock_t = 0;
        for (int c = 0; c < lvl_q.size(); c++) begin
            if (rst_q[c]) begin
                if (mode == 2) begin
                    emit_adv(lock_t, per, c);
                    exp_q.push_back(pack(c, 0, 1'b0, 1'b0, 1'b0, 0));
                end
                mode = 0;
                per  = 0;
                continue;
            end
            e = (c > 0) && !rst_q[c-1] && lvl_q[c] && !lvl_q[c-1];
            p = (c - last_e > MAXP) ? MAXP : (c - last_e);
            if (mode == 0) begin
                if (e) begin
                    mode   = 1;
                    last_e = c;
                end
            end else if (e && p >= MINP) begin
                if (mode == 2) emit_adv(lock_t, per, c);
                per    = p;
                lock_t = c;
                last_e = c;
                mode   = 2;
                exp_q.push_back(pack(c, 0, 1'b1, 1'b1, 1'b1, per));
            end else if (p >= MAXP) begin
                if (mode == 2) begin
                    emit_adv(lock_t, per, c);
                    exp_q.push_back(pack(c, 0, 1'b0, 1'b0, 1'b0, per));
                end
                mode = 0;
            end
        end
        if (mode == 2) emit_adv(lock_t, per, lvl_q.size());
    endtask

    // driver
    initial begin
        rst_in     = 1'b1;
        ir_tripped = 1'b0;

        add(3, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) add(1, 1'($urandom_range(0, 1)), 1'b1);
        add(1, 1'b1, 1'b1);
        add(6, 1'b1, 1'b0);
        add(60, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) rev(512);
        for (int i = 0; i < 3; i++) rev(625);
        for (int i = 0; i < 3; i++) rev($urandom_range(MINP, 1500));
        grev(512);
        rev(512);
        rev(512);
        rev(375);
        rev(375);
        rev(MAXP);
        rev(MAXP + 300);
        grev(700);
        rev(700);
        rev(700);
        rev(512);
        add(3, 1'b1, 1'b0);
        add(297, 1'b0, 1'b0);
        add(3, 1'b0, 1'b1);
        add(50, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) rev(512);
        add(100, 1'b0, 1'b0);

        build_model();

        for (int c = 0; c < lvl_q.size(); c++) begin
            @(negedge clk);
            rst_in     = rst_q[c];
            ir_tripped = lvl_q[c];
        end
    end

    // monitor / scoreboard
    initial begin
        logic [W-1:0]  e;
        logic [W-1:0]  obs;
        logic [DW-1:0] hold_d;
        logic [PW-1:0] hold_p;
        bit            prev_lk;
        bit            trig;
        int            n;
        hold_d  = '0;
        hold_p  = '0;
        prev_lk = 1'b0;
        @(negedge clk);
        n = lvl_q.size();
        for (int m = 0; m < n; m++) begin
            @(posedge clk);
            #1;
            trig    = theta_strobe || rev_strobe || (locked != prev_lk);
            prev_lk = locked;
            if (rst_q[m]) begin
                n_tests++;
                if ({dtheta, theta_strobe, rev_strobe, locked, period_out} !== '0) begin
                    n_fail++;
                    $display("FAIL reset_zero @%0d: got d=%0d th=%0b rv=%0b lk=%0b per=%0d, want all 0",
                             m, dtheta, theta_strobe, rev_strobe, locked, period_out);
                end
                hold_d = '0;
                hold_p = '0;
            end
            if (trig) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_event @%0d: got d=%0d rv=%0b th=%0b lk=%0b per=%0d, want no event",
                             m, dtheta, rev_strobe, theta_strobe, locked, period_out);
                end else begin
                    e   = exp_q.pop_front();
                    obs = pack(m, int'(dtheta), rev_strobe, theta_strobe, locked, int'(period_out));
                    if (obs !== e) begin
                        n_fail++;
                        $display("FAIL event: got @%0d d=%0d rv=%0b th=%0b lk=%0b per=%0d, want @%0d d=%0d rv=%0b th=%0b lk=%0b per=%0d",
                                 m, dtheta, rev_strobe, theta_strobe, locked, period_out,
                                 e[W-1 -: 32], e[PW+3 +: DW], e[PW+2], e[PW+1], e[PW], e[PW-1:0]);
                    end
                    hold_d = e[PW+3 +: DW];
                    hold_p = e[PW-1:0];
                end
            end else if (!rst_q[m]) begin
                n_tests++;
                if (dtheta !== hold_d || period_out !== hold_p) begin
                    n_fail++;
                    $display("FAIL hold @%0d: got d=%0d per=%0d, want d=%0d per=%0d",
                             m, dtheta, period_out, hold_d, hold_p);
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL missing_events: got %0d unobserved, want 0; next due @%0d",
                     exp_q.size(), exp_q[0][W-1 -: 32]);
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rotation_angle_tracker.md
# rotation_angle_tracker

Measures the spin period of the display from rising edges of the debounced IR beam-break signal. Produces a registered angular slice index `dtheta` in `[0, ROTATIONAL_RES-1]` that advances uniformly across each revolution, plus lock and strobe flags. It sits between the IR debouncer and the frame manager / HUB75 driver, which consume `dtheta` as the current angular column address. The design uses no divider: slice advance is done by Bresenham-style accumulation of `ROTATIONAL_RES` against the measured period.

## Interface
Parameters:
- `ROTATIONAL_RES`, default 1024: slices per revolution. Must be a power of 2 and at least 2.
- `PERIOD_WIDTH`, default 24: width of the period counter and period register.
- `MIN_PERIOD`, default 4096: shortest accepted period in cycles. Shorter edges are glitches. Must satisfy `MIN_PERIOD >= ROTATIONAL_RES`.
- `MAX_PERIOD`, default 2**24-1: timeout in cycles. Must satisfy `MAX_PERIOD <= 2**PERIOD_WIDTH-1` and `MAX_PERIOD > MIN_PERIOD`.

Ports:
- `clk_in` input 1: system clock.
- `rst_in` input 1: reset, asynchronous, active-high.
- `ir_tripped` input 1: debounced IR beam-break level, synchronous to `clk_in`.
- `dtheta` output `$clog2(ROTATIONAL_RES)`: current slice index.
- `theta_strobe` output 1: one-cycle pulse whenever `dtheta` is updated by an advance or by a restart to 0 while locked.
- `rev_strobe` output 1: one-cycle pulse on every accepted edge that enters or stays in LOCKED.
- `locked` output 1: high while in LOCKED.
- `period_out` output `PERIOD_WIDTH`: last accepted period in cycles.

## Operation
Edge detection:
- `ir_prev` is a register that holds `ir_tripped` from the previous cycle.
- `edge = ir_tripped & ~ir_prev`.

Period counter `period_cnt`:
- On an accepted edge, `period_cnt <= 1`.
- Otherwise it increments by 1 each cycle, saturating at `MAX_PERIOD`.
- At an edge cycle, `period_cnt` therefore equals the number of cycles P since the last accepted edge.

State machine:
- UNLOCKED (reset state):
  - `locked=0`, `dtheta` held at 0.
  - Any edge moves to ARMED and sets `period_cnt <= 1`.
- ARMED:
  - Edge with `P < MIN_PERIOD`: ignored. `period_cnt` keeps counting and the state is unchanged.
  - Edge with `P >= MIN_PERIOD`: move to LOCKED. Set `period_out <= P`, `dtheta <= 0`, `acc <= 0`, `period_cnt <= 1`. Pulse `rev_strobe` and `theta_strobe`.
  - `period_cnt == MAX_PERIOD`: move to UNLOCKED.
- LOCKED:
  - Accepted edge (`P >= MIN_PERIOD`): same updates as the ARMED→LOCKED transition and stay in LOCKED. This restart takes priority over any same-cycle advance, so an edge arriving before `dtheta` reaches `ROTATIONAL_RES-1` (speed-up) jumps `dtheta` directly to 0.
  - Edge with `P < MIN_PERIOD`: ignored.
  - `period_cnt == MAX_PERIOD` with no edge: move to UNLOCKED. Set `dtheta <= 0`, `locked <= 0`, `acc <= 0`. `period_out` is retained. No strobes.
  - Otherwise the advance rule applies.

Advance rule (LOCKED, no accepted edge, `dtheta < ROTATIONAL_RES-1`):
- Compute `sum = acc + ROTATIONAL_RES`. `acc` is `PERIOD_WIDTH+1` bits wide and `sum` has no overflow.
- If `sum >= period_out`: `acc <= sum - period_out`, `dtheta <= dtheta + 1`, pulse `theta_strobe`.
- Else: `acc <= sum`.
- Because `period_out >= MIN_PERIOD >= ROTATIONAL_RES`, there is at most one advance per cycle.

Saturation:
- When `dtheta == ROTATIONAL_RES-1`, it holds there and `acc` freezes until the next accepted edge or a timeout.
- `dtheta` never wraps on its own.

Simultaneous events:
- Edge and timeout in the same cycle: the edge is evaluated with `P = MAX_PERIOD` and is accepted. The timeout is not taken.

## Timing
- All outputs are registered.
- Reset values: `dtheta=0`, `theta_strobe=0`, `rev_strobe=0`, `locked=0`, `period_out=0`. Internally `acc=0`, `period_cnt=0`, `ir_prev=0`, state UNLOCKED.
- Asserting `rst_in` mid-operation forces all of these immediately and asynchronously.
- If `ir_tripped` is already high when reset releases, no edge is seen until it falls and rises again.
- Latency for an accepted edge on `ir_tripped` sampled at cycle t:
  - `dtheta=0`, `rev_strobe=1`, `theta_strobe=1` and `locked=1` are all visible at t+1.
  - `rev_strobe` and `theta_strobe` are 1 only at t+1.
- With a steady period P, exactly `ROTATIONAL_RES-1` advances occur before the next edge. The k-th advance lands `ceil(k*P/ROTATIONAL_RES)` cycles after the edge.
- Timeout: `locked` falls at the cycle after `period_cnt` reaches `MAX_PERIOD`.

## Test plan
- Reset: with `rst_in` high, toggle `ir_tripped` → all outputs stay 0. Release reset → outputs remain 0 with no edges.
- Lock with integer period (`ROTATIONAL_RES=1024`), rising edges every 8192 cycles → after the 2nd edge, `locked=1` and `period_out=8192`. `dtheta` increments every 8 cycles, reaches 1023 at 8184 cycles after the edge, holds, and returns to 0 one cycle after the 3rd edge. Exactly 1024 `theta_strobe` per revolution (1023 advances plus the restart).
- Non-integer period: edges every 10000 cycles → 1023 advances per revolution, the first at cycle 10 after the edge. Gaps are 9 or 10 cycles and `dtheta` never exceeds 1023.
- Glitch rejection: locked at 8192, inject a 1-cycle edge 100 cycles after an accepted edge → ignored. `dtheta` continues and `period_out` still reads 8192 at the next real edge.
- Speed-up and timeout (bench `MAX_PERIOD=65535`):
  - Period drops from 8192 to 6000 → `dtheta` jumps from about 749 to 0.
  - Then stop edges → `locked=0` and `dtheta=0` about 65535 cycles after the last edge.
  - Next edge → ARMED, and the edge after that re-locks.
- Reset mid-revolution while locked with `dtheta≈500` → all outputs are 0 immediately. The next two edges re-lock.
